// File: rtl/multicycle_control.sv
// Moore main controller for the multicycle MIPS-subset datapath: one state per clock,
// outputs registered from the next state except branch PCSel and the DECODE illegal flag.
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_ir_write,
  output logic       o_alu_src_a,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_pc_sel,
  output logic [1:0] o_pc_source,
  output logic [1:0] o_alu_src_b,
  output logic [3:0] o_alu_ctrl,
  output logic [3:0] o_state,
  output logic       o_retire,
  output logic       o_illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic [3:0] w_rtype_ctrl;
  logic       w_branch_take;
  logic       w_illegal;

  logic       r_iord, r_mem_read, r_mem_write, r_mem_to_reg, r_ir_write;
  logic       r_alu_src_a, r_reg_write, r_reg_dst, r_pc_sel, r_retire;
  logic [1:0] r_pc_source, r_alu_src_b;
  logic [3:0] r_alu_ctrl;

  always_comb begin
    w_funct_ok   = 1'b1;
    w_rtype_ctrl = 4'b0110;
    case (i_funct)
      6'h20:   w_rtype_ctrl = 4'b0110;
      6'h22:   w_rtype_ctrl = 4'b1110;
      6'h24:   w_rtype_ctrl = 4'b0000;
      6'h25:   w_rtype_ctrl = 4'b0001;
      6'h26:   w_rtype_ctrl = 4'b0010;
      6'h27:   w_rtype_ctrl = 4'b0011;
      6'h2A:   w_rtype_ctrl = 4'b1111;
      default: w_funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = w_funct_ok ? S_RTYPE_EX : S_FETCH;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDI_EX;
          default:        w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = S_MEMWB;
      S_RTYPE_EX: w_next = S_RTYPE_WB;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  // An unsupported instruction is the only way DECODE falls straight back to FETCH.
  assign w_illegal     = (r_state == S_DECODE) && (w_next == S_FETCH);
  assign w_branch_take = (i_op == OP_BNE) ? ~i_zero : i_zero;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_iord       <= 1'b0;
      r_mem_read   <= 1'b1;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_ir_write   <= 1'b1;
      r_alu_src_a  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_pc_sel     <= 1'b1;
      r_retire     <= 1'b0;
      r_pc_source  <= 2'b00;
      r_alu_src_b  <= 2'b01;
      r_alu_ctrl   <= 4'b0110;
    end else begin
      r_state      <= w_next;
      r_iord       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_ir_write   <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_pc_sel     <= 1'b0;
      r_retire     <= 1'b0;
      r_pc_source  <= 2'b00;
      r_alu_src_b  <= 2'b00;
      r_alu_ctrl   <= 4'b0000;
      case (w_next)
        S_FETCH: begin
          r_mem_read  <= 1'b1;
          r_ir_write  <= 1'b1;
          r_alu_src_b <= 2'b01;
          r_alu_ctrl  <= 4'b0110;
          r_pc_sel    <= 1'b1;
        end
        S_DECODE: begin
          r_alu_src_b <= 2'b11;
          r_alu_ctrl  <= 4'b0110;
        end
        S_MEMADR, S_ADDI_EX: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'b10;
          r_alu_ctrl  <= 4'b0110;
        end
        S_MEMRD: begin
          r_mem_read <= 1'b1;
          r_iord     <= 1'b1;
        end
        S_MEMWB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= 1'b1;
          r_retire     <= 1'b1;
        end
        S_MEMWR: begin
          r_mem_write <= 1'b1;
          r_iord      <= 1'b1;
          r_retire    <= 1'b1;
        end
        S_RTYPE_EX: begin
          r_alu_src_a <= 1'b1;
          r_alu_ctrl  <= w_rtype_ctrl;
        end
        S_RTYPE_WB: begin
          r_reg_write <= 1'b1;
          r_reg_dst   <= 1'b1;
          r_alu_ctrl  <= r_alu_ctrl;
          r_retire    <= 1'b1;
        end
        S_BRANCH: begin
          r_alu_src_a <= 1'b1;
          r_alu_ctrl  <= 4'b1110;
          r_pc_source <= 2'b01;
          r_retire    <= 1'b1;
        end
        S_ADDI_WB: begin
          r_reg_write <= 1'b1;
          r_retire    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write enables and status flags are masked for the whole time reset is held.
  assign o_iord       = r_iord;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write & ~i_reset;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_ir_write   = r_ir_write & ~i_reset;
  assign o_alu_src_a  = r_alu_src_a;
  assign o_reg_write  = r_reg_write & ~i_reset;
  assign o_reg_dst    = r_reg_dst;
  assign o_pc_sel     = ~i_reset & ((r_state == S_BRANCH) ? w_branch_take : r_pc_sel);
  assign o_pc_source  = r_pc_source;
  assign o_alu_src_b  = r_alu_src_b;
  assign o_alu_ctrl   = r_alu_ctrl;
  assign o_state      = r_state;
  assign o_retire     = r_retire & ~i_reset;
  assign o_illegal    = w_illegal & ~i_reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, including a small behavioural datapath
// that runs a five-instruction program through the controller.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_drv, funct_drv;
  logic       zero_drv;
  logic       integ, load;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a;
  logic       reg_write, reg_dst, pc_sel, retire, illegal;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_ctrl, state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
    .o_iord(iord), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_to_reg(mem_to_reg), .o_ir_write(ir_write), .o_alu_src_a(alu_src_a),
    .o_reg_write(reg_write), .o_reg_dst(reg_dst), .o_pc_sel(pc_sel),
    .o_pc_source(pc_source), .o_alu_src_b(alu_src_b), .o_alu_ctrl(alu_ctrl),
    .o_state(state), .o_retire(retire), .o_illegal(illegal)
  );

  // Behavioural datapath used only by the integrated program run.
  localparam logic [31:0] PROG [8] = '{32'h20010005, 32'h20020005, 32'h10220001,
                                       32'h20030001, 32'hAC010000, 32'h0, 32'h0, 32'h0};
  logic [31:0] pc, ir, a_q, b_q, alu_out, mdr, alu_res, src_a, src_b, mem_rd, addr;
  logic [31:0] mem [8];
  logic [31:0] rf  [8];
  logic [31:0] imm;
  logic [2:0]  dst;

  assign op    = integ ? ir[31:26] : op_drv;
  assign funct = integ ? ir[5:0]   : funct_drv;
  assign zero  = integ ? (alu_res == 32'd0) : zero_drv;
  assign imm   = {{16{ir[15]}}, ir[15:0]};
  assign addr  = iord ? alu_out : pc;
  assign mem_rd = mem[addr[4:2]];
  assign dst   = reg_dst ? ir[13:11] : ir[18:16];

  always_comb begin
    src_a = alu_src_a ? a_q : pc;
    case (alu_src_b)
      2'b00:   src_b = b_q;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = imm;
      default: src_b = {imm[29:0], 2'b00};
    endcase
    case (alu_ctrl)
      4'b0000: alu_res = src_a & src_b;
      4'b0001: alu_res = src_a | src_b;
      4'b0010: alu_res = src_a ^ src_b;
      4'b0011: alu_res = ~(src_a | src_b);
      4'b0110: alu_res = src_a + src_b;
      4'b1110: alu_res = src_a - src_b;
      4'b1111: alu_res = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= PROG[i];
        rf[i]  <= 32'd0;
      end
    end else begin
      if (mem_write) mem[alu_out[4:2]] <= b_q;
      if (reg_write && dst != 3'd0) rf[dst] <= mem_to_reg ? mdr : alu_out;
    end
    if (reset) pc <= 32'd0;
    else if (pc_sel) pc <= (pc_source == 2'b00) ? alu_res : alu_out;
    if (ir_write) ir <= mem_rd;
    mdr     <= mem_rd;
    a_q     <= rf[ir[23:21]];
    b_q     <= rf[ir[18:16]];
    alu_out <= alu_res;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (reg_write !== 1'b0 || mem_write !== 1'b0 || ir_write !== 1'b0 || pc_sel !== 1'b0 || retire !== 1'b0)
      $display("FAIL reset_enables: got rw=%0b mw=%0b irw=%0b pcs=%0b ret=%0b want all 0", reg_write, mem_write, ir_write, pc_sel, retire);
    else n_pass++;
    // Walk an add up to RTYPE_EX, then pull reset for three cycles.
    reset = 1'b0; op_drv = 6'h00; funct_drv = 6'h20;
    tick(); tick();
    #1;
    n_checks++; if (state !== 4'd6) $display("FAIL reset_pre_state: got %0d want 6", state); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL reset_mid_regwrite: got %0b want 0", reg_write); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_checks++; if (state !== 4'd0 || reg_write !== 1'b0 || ir_write !== 1'b0)
        $display("FAIL reset_hold: cycle %0d got state=%0d rw=%0b irw=%0b want 0/0/0", i, state, reg_write, ir_write);
      else n_pass++;
    end
    reset = 1'b0;
    #1;
    n_checks++; if (state !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b1 || pc_sel !== 1'b1)
      $display("FAIL reset_first_fetch: got state=%0d mr=%0b irw=%0b pcs=%0b want 0/1/1/1", state, mem_read, ir_write, pc_sel);
    else n_pass++;
  endtask

  task automatic test_memory();
    logic [3:0] lw_seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [3:0] sw_seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    op_drv = 6'h23; funct_drv = 6'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (state !== lw_seq[i]) $display("FAIL lw_state: cycle %0d got %0d want %0d", i, state, lw_seq[i]); else n_pass++;
      n_checks++; if (mem_to_reg !== (i == 4) || mem_write !== 1'b0 || retire !== (i == 4) || illegal !== 1'b0)
        $display("FAIL lw_ctrl: cycle %0d got m2r=%0b mw=%0b ret=%0b ill=%0b", i, mem_to_reg, mem_write, retire, illegal);
      else n_pass++;
      if (i == 3) begin
        n_checks++; if (iord !== 1'b1 || mem_read !== 1'b1) $display("FAIL lw_memrd: got iord=%0b mr=%0b want 1/1", iord, mem_read); else n_pass++;
      end
      tick();
    end
    op_drv = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (state !== sw_seq[i]) $display("FAIL sw_state: cycle %0d got %0d want %0d", i, state, sw_seq[i]); else n_pass++;
      n_checks++; if (mem_write !== (i == 3) || mem_to_reg !== 1'b0 || reg_write !== 1'b0 || retire !== (i == 3))
        $display("FAIL sw_ctrl: cycle %0d got mw=%0b m2r=%0b rw=%0b ret=%0b", i, mem_write, mem_to_reg, reg_write, retire);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [3:0] exp [7] = '{4'b0110, 4'b1110, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1111};
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    for (int k = 0; k < 7; k++) begin
      op_drv = 6'h00; funct_drv = fn[k];
      for (int i = 0; i < 4; i++) begin
        if (i == 3) funct_drv = 6'h01;
        #1;
        n_checks++; if (state !== seq[i]) $display("FAIL rtype_state: fn %0h cycle %0d got %0d want %0d", fn[k], i, state, seq[i]); else n_pass++;
        if (i >= 2) begin
          n_checks++; if (alu_ctrl !== exp[k]) $display("FAIL rtype_aluctrl: fn %0h state %0d got %b want %b", fn[k], state, alu_ctrl, exp[k]); else n_pass++;
        end
        if (i == 3) begin
          n_checks++; if (reg_dst !== 1'b1 || reg_write !== 1'b1 || retire !== 1'b1)
            $display("FAIL rtype_wb: fn %0h got rd=%0b rw=%0b ret=%0b want 1/1/1", fn[k], reg_dst, reg_write, retire);
          else n_pass++;
        end
        tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] bop [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       bz  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       bpc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      op_drv = bop[k]; funct_drv = 6'h00; zero_drv = bz[k];
      #1;
      n_checks++; if (state !== 4'd0) $display("FAIL branch_start: case %0d got %0d want 0", k, state); else n_pass++;
      tick(); tick();
      #1;
      n_checks++; if (state !== 4'd8 || pc_sel !== bpc[k] || pc_source !== 2'b01 || alu_ctrl !== 4'b1110 || retire !== 1'b1)
        $display("FAIL branch_ctrl: case %0d got st=%0d pcs=%0b src=%b alu=%b ret=%0b want pcs=%0b", k, state, pc_sel, pc_source, alu_ctrl, retire, bpc[k]);
      else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (state !== 4'd0) $display("FAIL branch_latency: got %0d want 0", state); else n_pass++;
    zero_drv = 1'b0;
  endtask

  task automatic test_illegal();
    logic [5:0] iop [2] = '{6'h3F, 6'h00};
    logic [5:0] ifn [2] = '{6'h00, 6'h01};
    for (int k = 0; k < 2; k++) begin
      op_drv = iop[k]; funct_drv = ifn[k];
      tick();
      #1;
      n_checks++; if (state !== 4'd1 || illegal !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0)
        $display("FAIL illegal_decode: case %0d got st=%0d ill=%0b rw=%0b mw=%0b want 1/1/0/0", k, state, illegal, reg_write, mem_write);
      else n_pass++;
      tick();
      #1;
      n_checks++; if (state !== 4'd0 || illegal !== 1'b0 || retire !== 1'b0)
        $display("FAIL illegal_next: case %0d got st=%0d ill=%0b ret=%0b want 0/0/0", k, state, illegal, retire);
      else n_pass++;
    end
  endtask

  task automatic test_integrated();
    int n_ret = 0;
    integ = 1'b1; load = 1'b1; reset = 1'b1;
    tick(); tick();
    load = 1'b0; reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (reg_write && dst == 3'd3) $display("FAIL integ_r3_write: cycle %0d wrote r3", c + 1);
      if (retire) n_ret++;
      tick();
    end
    #1;
    n_checks++; if (n_ret !== 4) $display("FAIL integ_retires: got %0d want 4", n_ret); else n_pass++;
    n_checks++; if (state !== 4'd0 || pc !== 32'd20) $display("FAIL integ_end: got st=%0d pc=%0d want 0/20", state, pc); else n_pass++;
    n_checks++; if (rf[1] !== 32'd5 || rf[2] !== 32'd5) $display("FAIL integ_regs: got r1=%0d r2=%0d want 5/5", rf[1], rf[2]); else n_pass++;
    n_checks++; if (rf[3] !== 32'd0) $display("FAIL integ_r3: got %0d want 0", rf[3]); else n_pass++;
    n_checks++; if (mem[0] !== 32'd5) $display("FAIL integ_mem0: got %0h want 5", mem[0]); else n_pass++;
  endtask

  initial begin
    integ = 1'b0; load = 1'b1; reset = 1'b1;
    op_drv = 6'h00; funct_drv = 6'h20; zero_drv = 1'b0;
    test_reset();
    load = 1'b0;
    test_memory();
    test_rtype();
    test_branch();
    test_illegal();
    test_integrated();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
